instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage that drives the word-addressed instruction memory and delivers instructions to decode through a one-entry IF/ID register with a valid/ready handshake. Owns the program counter, handles decode back-pressure, branch/jump redirects with flush, and out-of-range PC faulting. Sits between the instruction memory, which reads combinationally on `pc_address` while enabled, and the decode stage.

## Interface
Parameters:
- `MEM_DEPTH`, 32: number of 32-bit words in instruction memory; legal PCs are 0..MEM_DEPTH-1.
- `RESET_PC`, 0: word index fetched first after reset.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_en`  out  1  instruction memory enable.
- `imem_addr`  out  32  word index to memory (connects to `pc_address`).
- `imem_data`  in  32  instruction word from memory (from `instruction_set`), valid same cycle.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  word-index target of the redirect.
- `id_ready`  in  1  decode accepts `id_instr` this cycle.
- `id_valid`  out  1  IF/ID register holds a valid instruction.
- `id_instr`  out  32  fetched instruction.
- `id_pc`  out  32  word index the instruction came from.
- `fetch_fault`  out  1  PC out of range; fetching halted.
- `fetch_count`  out  32  number of instructions accepted by decode.

## Operation
- FSM states: BOOT, RUN, FAULT. Reset enters BOOT.
- BOOT: lasts exactly one cycle after reset release; `imem_en`=0; next state RUN.
- RUN: `imem_addr`=pc. Let `adv` = (!id_valid || id_ready) && pc < MEM_DEPTH && !redirect_valid.
  - `imem_en`=`adv`.
  - On `adv`: id_instr<=imem_data, id_pc<=pc, id_valid<=1, pc<=pc+1.
  - If !`adv` and `id_ready` and no redirect: id_valid<=0 (drained, nothing new).
  - Stall (id_valid && !id_ready): pc, id_* held unchanged.
  - pc >= MEM_DEPTH without redirect: no fetch, next state FAULT. The IF/ID entry still drains normally.
- Redirect, in any state, has highest priority, including over stall: id_valid<=0 (flush, regardless of `id_ready`) and pc<=redirect_pc.
  - If redirect_pc < MEM_DEPTH: next state RUN and fetch_fault<=0.
  - Otherwise: next state FAULT.
- FAULT: `imem_en`=0, `fetch_fault`=1. Exit only through redirect.
- `fetch_count` increments on every cycle with id_valid && id_ready && !redirect_valid. It wraps at 2^32.
- Width rules: pc is 32 bits, +1 modulo 2^32. The range check is an unsigned compare against MEM_DEPTH. No byte addressing.

## Timing
- Reset values: pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, imem_en=0, fetch_fault=0, fetch_count=0, state=BOOT.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge. An in-flight instruction is lost.
- Fetch latency: the address is presented in cycle N and the instruction is visible on id_* in cycle N+1.
- Throughput: one instruction per cycle while `id_ready`=1. The first valid output appears 2 cycles after reset release.
- A stall holds id_* stable for as long as `id_ready`=0.
- Redirect in cycle N:
  - id_valid=0 in cycle N+1.
  - The target instruction appears in cycle N+2.
  - One bubble results.
- `imem_en` and `imem_addr` are combinational from state, pc, handshake and redirect inputs. All other outputs are registered.

## Structure
- The shared package `cpu_pkg` holds:
  - the FSM state enum (BOOT/RUN/FAULT);
  - `WORD_W`=32;
  - the `RESET_PC` default.
- One natural sub-module is `if_id_reg`: the valid/instr/pc holding register with load, hold and flush controls. PC, FSM and counter stay in the top module.

## Test plan
- Reset, then `id_ready`=1 with memory words 0..3 = 0xA0,0xA1,0xA2,0xA3 -> id_instr sequence 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, id_pc 0,1,2,3, first valid 2 cycles after reset release; fetch_count=4 after four accepts.
- Hold `id_ready`=0 for 3 cycles while id_pc=2 -> id_instr/id_pc held at word 2, imem_en=0; on release next id_pc=3, and no word is skipped or duplicated.
- Redirect to 13 while id_pc=1 and `id_ready`=0 -> next cycle id_valid=0, following cycle id_pc=13 with memory word 13; fetch_count not incremented for the flushed entry.
- Run sequentially to pc=31 with MEM_DEPTH=32 -> word 31 delivered, then fetch_fault=1, imem_en=0, id_valid drops after accept; redirect to 7 -> fault clears and id_pc=7 follows.
- Redirect to 40 -> fetch_fault=1, no fetch; repeated redirects to 7 every cycle -> id_pc stays invalid until redirect_valid deasserts.
- Assert `rst` asynchronously between clock edges mid-stream -> all outputs at reset values before the next edge; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch FSM state encoding, reset PC default.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input, IF/ID handshake
// and status outputs.
//   master : fetch stage (drives imem_en/addr, id_*, fetch_fault, fetch_count)
//   slave  : environment (memory, decode, branch unit)
interface instruction_fetch_if;
    import cpu_pkg::*;

    logic              imem_en;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_data;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [WORD_W-1:0] id_instr;
    logic [WORD_W-1:0] id_pc;
    logic              fetch_fault;
    logic [WORD_W-1:0] fetch_count;

    modport master (
        output imem_en, imem_addr, id_valid, id_instr, id_pc, fetch_fault, fetch_count,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_en, imem_addr, id_valid, id_instr, id_pc, fetch_fault, fetch_count,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// One-entry IF/ID holding register.
//   load  : capture instr_in/pc_in and mark valid (wins over flush)
//   flush : drop the entry (valid cleared, payload kept)
//   neither : hold
module if_id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc_in,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_q,    pc_d;

    // Next-entry selection
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC and fetch FSM (BOOT/RUN/FAULT), reads the
// combinational instruction memory, and feeds decode through a one-entry IF/ID
// register with valid/ready handshake. Redirects flush and retarget the PC; an
// out-of-range PC halts fetching until a redirect.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instruction_fetch_if master (imem port, redirect, IF/ID, status)
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       MEM_DEPTH = 32,
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    localparam logic [1:0] BOOT  = ST_BOOT;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] FAULT = ST_FAULT;

    localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(MEM_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic              adv_c;
    logic              flush_c;

    // Next-state, PC, status and IF/ID control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        adv_c   = 1'b0;
        flush_c = 1'b0;

        if (bus.id_valid && bus.id_ready && !bus.redirect_valid)
            count_d = count_q + WORD_W'(1);

        if (bus.redirect_valid) begin
            // Redirect beats everything, including a stalled entry
            flush_c = 1'b1;
            pc_d    = bus.redirect_pc;
            if (bus.redirect_pc < DEPTH_W) begin
                state_d = RUN;
                fault_d = 1'b0;
            end else begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (pc_q < DEPTH_W) begin
                        adv_c = !bus.id_valid || bus.id_ready;
                        if (adv_c)
                            pc_d = pc_q + WORD_W'(1);
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end
                FAULT: fault_d = 1'b1;
                default: state_d = BOOT;
            endcase
            // Entry consumed with nothing new behind it
            if (!adv_c && bus.id_ready)
                flush_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign bus.imem_en     = adv_c;
    assign bus.imem_addr   = pc_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_count = count_q;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (adv_c),
        .flush    (flush_c),
        .instr_in (bus.imem_data),
        .pc_in    (pc_q),
        .valid    (bus.id_valid),
        .instr    (bus.id_instr),
        .pc       (bus.id_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory word i holds 0xA0+i.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_if bus ();

    instruction_fetch #(.MEM_DEPTH(32), .RESET_PC(32'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory model
    assign bus.imem_data = (bus.imem_addr < 32'd32) ? (32'h0000_00A0 + bus.imem_addr) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] cnt);
        chk({tag, ".valid"}, 32'(bus.id_valid), 32'(v));
        if (v) begin
            chk({tag, ".instr"}, bus.id_instr, instr);
            chk({tag, ".pc"}, bus.id_pc, pc);
        end
        chk({tag, ".count"}, bus.fetch_count, cnt);
    endtask

    initial begin
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;

        // Reset state
        tick();
        chk("rst.valid", 32'(bus.id_valid), 32'd0);
        chk("rst.instr", bus.id_instr, 32'd0);
        chk("rst.pc", bus.id_pc, 32'd0);
        chk("rst.fault", 32'(bus.fetch_fault), 32'd0);
        chk("rst.count", bus.fetch_count, 32'd0);
        chk("rst.en", 32'(bus.imem_en), 32'd0);
        rst = 1'b0;

        // BOOT cycle -> RUN, first fetch of word 0
        tick();
        chk("boot.en", 32'(bus.imem_en), 32'd1);
        chk("boot.addr", bus.imem_addr, 32'd0);
        chk_id("boot", 1'b0, 32'd0, 32'd0, 32'd0);

        // Streaming at one per cycle
        tick(); chk_id("s0", 1'b1, 32'hA0, 32'd0, 32'd0);
        tick(); chk_id("s1", 1'b1, 32'hA1, 32'd1, 32'd1);
        tick(); chk_id("s2", 1'b1, 32'hA2, 32'd2, 32'd2);

        // Stall three cycles on word 2
        bus.id_ready = 1'b0;
        #1 chk("stall.en", 32'(bus.imem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_id("stall", 1'b1, 32'hA2, 32'd2, 32'd2);
            chk("stall.en_hold", 32'(bus.imem_en), 32'd0);
        end
        bus.id_ready = 1'b1;
        tick(); chk_id("rel3", 1'b1, 32'hA3, 32'd3, 32'd3);
        tick(); chk_id("rel4", 1'b1, 32'hA4, 32'd4, 32'd4);

        // Redirect to 13 while decode is ready: flushed entry is not counted
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd13;
        #1 chk("redir.en", 32'(bus.imem_en), 32'd0);
        tick(); chk_id("redir.bubble", 1'b0, 32'd0, 32'd0, 32'd4);
        bus.redirect_valid = 1'b0;
        tick(); chk_id("redir.tgt", 1'b1, 32'hAD, 32'd13, 32'd4);

        // Redirect to 29 overriding a stall
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd29;
        tick(); chk_id("redir2.bubble", 1'b0, 32'd0, 32'd0, 32'd4);
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b1;
        tick(); chk_id("w29", 1'b1, 32'hBD, 32'd29, 32'd4);
        tick(); chk_id("w30", 1'b1, 32'hBE, 32'd30, 32'd5);
        tick(); chk_id("w31", 1'b1, 32'hBF, 32'd31, 32'd6);
        chk("end.en", 32'(bus.imem_en), 32'd0);
        chk("end.addr", bus.imem_addr, 32'd32);

        // Fell off the end of memory
        tick();
        chk_id("fault0", 1'b0, 32'd0, 32'd0, 32'd7);
        chk("fault0.flag", 32'(bus.fetch_fault), 32'd1);
        chk("fault0.en", 32'(bus.imem_en), 32'd0);
        tick();
        chk("fault1.flag", 32'(bus.fetch_fault), 32'd1);
        chk_id("fault1", 1'b0, 32'd0, 32'd0, 32'd7);

        // Recover via redirect to 7
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd7;
        tick();
        chk("rec.flag", 32'(bus.fetch_fault), 32'd0);
        chk_id("rec.bubble", 1'b0, 32'd0, 32'd0, 32'd7);
        bus.redirect_valid = 1'b0;
        tick(); chk_id("rec7", 1'b1, 32'hA7, 32'd7, 32'd7);
        tick(); chk_id("rec8", 1'b1, 32'hA8, 32'd8, 32'd8);

        // Redirect out of range
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd40;
        tick();
        chk("oor.flag", 32'(bus.fetch_fault), 32'd1);
        chk("oor.en", 32'(bus.imem_en), 32'd0);
        chk_id("oor", 1'b0, 32'd0, 32'd0, 32'd8);

        // Repeated redirects to 7 keep the entry empty
        bus.redirect_pc = 32'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rep.flag", 32'(bus.fetch_fault), 32'd0);
            chk("rep.en", 32'(bus.imem_en), 32'd0);
            chk_id("rep", 1'b0, 32'd0, 32'd0, 32'd8);
        end
        bus.redirect_valid = 1'b0;
        tick(); chk_id("rep7", 1'b1, 32'hA7, 32'd7, 32'd8);
        tick(); chk_id("rep8", 1'b1, 32'hA8, 32'd8, 32'd9);

        // Asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        chk("arst.valid", 32'(bus.id_valid), 32'd0);
        chk("arst.instr", bus.id_instr, 32'd0);
        chk("arst.pc", bus.id_pc, 32'd0);
        chk("arst.count", bus.fetch_count, 32'd0);
        chk("arst.fault", 32'(bus.fetch_fault), 32'd0);
        chk("arst.en", 32'(bus.imem_en), 32'd0);
        chk("arst.addr", bus.imem_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick(); chk_id("re.boot", 1'b0, 32'd0, 32'd0, 32'd0);
        tick(); chk_id("re0", 1'b1, 32'hA0, 32'd0, 32'd0);
        tick(); chk_id("re1", 1'b1, 32'hA1, 32'd1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
